fifo_access_ctrl: RTL and testbench

- Sequencing controller and two-port arbiter in front of the shared byte buffer; the buffer uses a level push/pop protocol with hold-until-released semantics.
- Lets two requesters share one buffer through req/ack handshakes, e.g. port 0 = RS232 receiver, port 1 = command processor.
- Generates the buffer's push/pop levels with fixed hold and recovery timing.
- Rejects overflow/underflow requests, supports flush, and tracks occupancy.

---
 rtl/fifo_access_ctrl_pkg.sv | 21 ++
 rtl/fifo_access_ctrl_if.sv | 22 ++
 rtl/fifo_access_ctrl_arb.sv | 32 +++
 rtl/fifo_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_fifo_access_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_access_ctrl_pkg.sv
// rtl/fifo_access_ctrl_pkg.sv - shared types and constants for the buffer access controller
package fifo_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_CLR,
      ST_IDLE,
      ST_GRANT,
      ST_ASSERT,
      ST_RELEASE,
      ST_DONE
   } state_t;

   localparam logic OP_PUSH = 1'b1;
   localparam logic OP_POP  = 1'b0;

   localparam int PORT0   = 0;
   localparam int PORT1   = 1;
   localparam int COUNT_W = 16;
   localparam int TCNT_W  = 8;

endpackage

// File: rtl/fifo_access_ctrl_if.sv
// rtl/fifo_access_ctrl_if.sv - requester-side req/ack bundle for the buffer access controller
interface fifo_access_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic [1:0]            req;
   logic [1:0]            wr;
   logic [DATA_WIDTH-1:0] wdata0;
   logic [DATA_WIDTH-1:0] wdata1;
   logic [1:0]            ack;
   logic                  err;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req, wr, wdata0, wdata1,
      input  ack, err, rdata
   );

   modport slave (
      input  req, wr, wdata0, wdata1,
      output ack, err, rdata
   );
endinterface

// File: rtl/fifo_access_ctrl_arb.sv
// rtl/fifo_access_ctrl_arb.sv - two-input round-robin arbiter with last-grant memory
import fifo_ctrl_pkg::*;

module rr_arbiter2 (
   input  logic       clk,
   input  logic       clear_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   // last_gnt = 1 means port 1 was served last, so port 0 wins a tie
   logic last_gnt;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         last_gnt <= 1'b1;
      end else if (en && (req != 2'b00)) begin
         last_gnt <= gnt[PORT1];
      end
   end

endmodule

// File: rtl/fifo_access_ctrl.sv
// rtl/fifo_access_ctrl.sv - two-port sequencer driving a level push/pop byte buffer
import fifo_ctrl_pkg::*;

module fifo_access_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int FIFO_SIZE      = 8,
   parameter int OP_CYCLES      = 3,
   parameter int RECOVER_CYCLES = 2,
   parameter int FLUSH_CYCLES   = 2
) (
   input  logic                  clk,
   input  logic                  clear_n,
   fifo_access_ctrl_if.slave     bus,
   input  logic                  flush,
   output logic                  busy,
   output logic [COUNT_W-1:0]    count,
   output logic                  buf_clear,
   output logic                  buf_push,
   output logic                  buf_pop,
   output logic [DATA_WIDTH-1:0] buf_wdata,
   input  logic [DATA_WIDTH-1:0] buf_rdata,
   input  logic                  buf_full,
   input  logic                  buf_empty
);
   localparam logic [COUNT_W-1:0] FULL_CNT  = COUNT_W'(FIFO_SIZE);
   localparam logic [TCNT_W-1:0]  OP_END    = TCNT_W'(OP_CYCLES);
   localparam logic [TCNT_W-1:0]  REC_END   = TCNT_W'(RECOVER_CYCLES - 1);
   localparam logic [TCNT_W-1:0]  FLUSH_END = TCNT_W'(FLUSH_CYCLES);

   state_t                 state;
   logic [TCNT_W-1:0]      tcnt;
   logic                   port_q;
   logic                   op_q;
   logic [1:0]             ack_q;
   logic                   err_q;
   logic [DATA_WIDTH-1:0]  rdata_q;
   logic [1:0]             gnt;
   logic                   arb_en;
   logic                   reject;

   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;

   assign arb_en = (state == ST_IDLE) && !flush;
   assign reject = (op_q == OP_PUSH) ? (buf_full  || (count == FULL_CNT))
                                     : (buf_empty || (count == '0));

   rr_arbiter2 u_arb (
      .clk     (clk),
      .clear_n (clear_n),
      .en      (arb_en),
      .req     (bus.req),
      .gnt     (gnt)
   );

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         state     <= ST_CLR;
         tcnt      <= '0;
         port_q    <= 1'b0;
         op_q      <= OP_POP;
         ack_q     <= 2'b00;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         count     <= '0;
         busy      <= 1'b1;
         buf_clear <= 1'b1;
         buf_push  <= 1'b0;
         buf_pop   <= 1'b0;
         buf_wdata <= '0;
      end else begin
         ack_q <= 2'b00;
         case (state)
            // reset enters with tcnt = 0 and flush with tcnt = 1, so both hold
            // buf_clear for FLUSH_CYCLES cycles after the triggering edge
            ST_CLR: begin
               if (tcnt == FLUSH_END) begin
                  state     <= ST_IDLE;
                  buf_clear <= 1'b0;
                  busy      <= 1'b0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            ST_IDLE: begin
               if (flush) begin
                  state     <= ST_CLR;
                  tcnt      <= TCNT_W'(1);
                  buf_clear <= 1'b1;
                  count     <= '0;
                  busy      <= 1'b1;
               end else if (gnt != 2'b00) begin
                  state     <= ST_GRANT;
                  busy      <= 1'b1;
                  port_q    <= gnt[PORT1];
                  op_q      <= gnt[PORT1] ? bus.wr[PORT1] : bus.wr[PORT0];
                  buf_wdata <= gnt[PORT1] ? bus.wdata1 : bus.wdata0;
               end
            end
            ST_GRANT: begin
               tcnt <= '0;
               if (reject) begin
                  state         <= ST_DONE;
                  ack_q[port_q] <= 1'b1;
                  err_q         <= 1'b1;
               end else begin
                  state <= ST_ASSERT;
               end
            end
            // first ASSERT cycle is a setup cycle with buf_wdata already stable
            ST_ASSERT: begin
               if (tcnt == OP_END) begin
                  state    <= ST_RELEASE;
                  tcnt     <= '0;
                  buf_push <= 1'b0;
                  buf_pop  <= 1'b0;
               end else begin
                  tcnt     <= tcnt + 1'b1;
                  buf_push <= (op_q == OP_PUSH);
                  buf_pop  <= (op_q == OP_POP);
               end
            end
            ST_RELEASE: begin
               if (tcnt == '0) begin
                  if (op_q == OP_POP) begin
                     rdata_q <= buf_rdata;
                     count   <= count - 1'b1;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
               if (tcnt == REC_END) begin
                  state         <= ST_DONE;
                  ack_q[port_q] <= 1'b1;
                  err_q         <= 1'b0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               err_q <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_CLR;
               tcnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// tb/tb_fifo_access_ctrl.sv - self-checking bench for fifo_access_ctrl with a behavioural buffer model
module tb_fifo_access_ctrl;

   localparam int DW        = 8;
   localparam int DEPTH     = 8;
   localparam int OPC       = 3;
   localparam int RECC      = 2;
   localparam int LAT_OK    = 3 + OPC + RECC;
   localparam int LAT_REJ   = 2;

   logic          clk = 1'b0;
   logic          clear_n;
   logic          flush;
   logic          busy;
   logic [15:0]   count;
   logic          buf_clear, buf_push, buf_pop;
   logic [DW-1:0] buf_wdata;
   logic [DW-1:0] buf_rdata;
   logic          buf_full, buf_empty;

   int checks   = 0;
   int failures = 0;

   fifo_access_ctrl_if #(.DATA_WIDTH(DW)) ifc ();

   fifo_access_ctrl #(
      .DATA_WIDTH(DW), .FIFO_SIZE(DEPTH), .OP_CYCLES(OPC),
      .RECOVER_CYCLES(RECC), .FLUSH_CYCLES(2)
   ) dut (
      .clk       (clk),
      .clear_n   (clear_n),
      .bus       (ifc),
      .flush     (flush),
      .busy      (busy),
      .count     (count),
      .buf_clear (buf_clear),
      .buf_push  (buf_push),
      .buf_pop   (buf_pop),
      .buf_wdata (buf_wdata),
      .buf_rdata (buf_rdata),
      .buf_full  (buf_full),
      .buf_empty (buf_empty)
   );

   always #5 clk = ~clk;

   // external byte buffer: captures on push rising edge, presents data on pop rising edge
   logic [DW-1:0] bq[$];
   int            bq_n = 0;
   logic          prev_push = 1'b0, prev_pop = 1'b0;

   initial buf_rdata = '0;

   always @(posedge clk) begin
      if (buf_clear) begin
         bq.delete();
      end else begin
         if (buf_push && !prev_push) bq.push_back(buf_wdata);
         if (buf_pop && !prev_pop && bq.size() > 0) buf_rdata <= bq.pop_front();
      end
      prev_push <= buf_push;
      prev_pop  <= buf_pop;
      bq_n      <= bq.size();
   end

   assign buf_full  = (bq_n == DEPTH);
   assign buf_empty = (bq_n == 0);

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model: expected contents, arbitration memory and last popped byte
   logic [DW-1:0] mq[$];
   logic          m_last;
   logic [DW-1:0] m_rdata;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_last  = 1'b1;
      m_rdata = '0;
   endtask

   task automatic reset_seq();
      clear_n  = 1'b0;
      ifc.req  = 2'b00;
      flush    = 1'b0;
      tick();
      tick();
      chk("rst_buf_clear", 32'(buf_clear), 32'd1);
      chk("rst_push_pop", {30'd0, buf_push, buf_pop}, 32'd0);
      chk("rst_ack_err", {29'd0, ifc.ack, ifc.err}, 32'd0);
      chk("rst_rdata", 32'(ifc.rdata), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      model_clear();
      clear_n = 1'b1;
      tick();
      chk("clr_cycle1", 32'(buf_clear), 32'd1);
      tick();
      chk("clr_cycle2", 32'(buf_clear), 32'd1);
      tick();
      chk("clr_done", 32'(buf_clear), 32'd0);
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_ack", 32'(ifc.ack), 32'd0);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      model_clear_keep_arb();
      chk("flush_clear1", 32'(buf_clear), 32'd1);
      chk("flush_count", 32'(count), 32'd0);
      tick();
      chk("flush_clear2", 32'(buf_clear), 32'd1);
      tick();
      chk("flush_end", {30'd0, buf_clear, busy}, 32'd0);
   endtask

   task automatic model_clear_keep_arb();
      mq.delete();
   endtask

   // raise the requested ports and serve until every one is acknowledged
   task automatic run(input logic [1:0] rq, input logic [1:0] w,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      logic [1:0]    pend;
      logic          p, op, rej;
      logic [DW-1:0] data;
      logic [1:0]    exp_ack;
      int            edges, npush, npop, exp_lat;
      logic          wd_ok, excl_ok;
      bit            first;
      pend       = rq;
      ifc.wr     = w;
      ifc.wdata0 = d0;
      ifc.wdata1 = d1;
      ifc.req    = rq;
      first      = 1'b1;
      while (pend != 2'b00) begin
         p       = (pend == 2'b11) ? ~m_last : pend[1];
         op      = w[p];
         data    = p ? d1 : d0;
         rej     = op ? (mq.size() == DEPTH) : (mq.size() == 0);
         exp_lat = (rej ? LAT_REJ : LAT_OK) + (first ? 0 : 1);
         exp_ack = 2'b01 << p;
         edges = 0; npush = 0; npop = 0; wd_ok = 1'b1; excl_ok = 1'b1;
         do begin
            tick();
            edges++;
            if (buf_push) npush++;
            if (buf_pop) npop++;
            if (buf_push && buf_wdata !== data) wd_ok = 1'b0;
            if ((buf_push && buf_pop) || (buf_clear && (buf_push || buf_pop))) excl_ok = 1'b0;
         end while (ifc.ack == 2'b00 && edges < 40);
         m_last = p;
         if (!rej) begin
            if (op) mq.push_back(data);
            else m_rdata = mq.pop_front();
         end
         chk("ack_port", 32'(ifc.ack), 32'(exp_ack));
         chk("ack_latency", 32'(edges), 32'(exp_lat));
         chk("err", 32'(ifc.err), 32'(rej));
         chk("rdata", 32'(ifc.rdata), 32'(m_rdata));
         chk("count", 32'(count), 32'(mq.size()));
         chk("push_cycles", 32'(npush), (!rej && op) ? 32'(OPC) : 32'd0);
         chk("pop_cycles", 32'(npop), (!rej && !op) ? 32'(OPC) : 32'd0);
         chk("wdata_excl", {30'd0, wd_ok, excl_ok}, 32'd3);
         pend[p] = 1'b0;
         ifc.req = pend;
         first   = 1'b0;
      end
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      clear_n    = 1'b0;
      flush      = 1'b0;
      ifc.req    = 2'b00;
      ifc.wr     = 2'b00;
      ifc.wdata0 = '0;
      ifc.wdata1 = '0;
      model_clear();

      reset_seq();
      run(2'b01, 2'b01, 8'hA5, 8'h00);
      run(2'b10, 2'b00, 8'h00, 8'h00);
      chk("pop_a5", 32'(ifc.rdata), 32'hA5);
      run(2'b10, 2'b00, 8'h00, 8'h00);

      reset_seq();
      run(2'b11, 2'b11, 8'h11, 8'h22);
      chk("both_count", 32'(count), 32'd2);
      run(2'b01, 2'b00, 8'h00, 8'h00);
      chk("pop_11", 32'(ifc.rdata), 32'h11);
      run(2'b01, 2'b00, 8'h00, 8'h00);
      chk("pop_22", 32'(ifc.rdata), 32'h22);

      for (int i = 0; i < DEPTH; i++) run(2'b10, 2'b10, 8'h00, 8'($urandom));
      run(2'b01, 2'b01, 8'hFF, 8'h00);
      chk("full_count", 32'(count), 32'd8);
      run(2'b11, 2'b00, 8'h00, 8'h00);

      // reset while buf_push is high: no ack, everything cleared
      ifc.wr  = 2'b01;
      ifc.req = 2'b01;
      reset_seq_mid();

      run(2'b01, 2'b01, 8'h5A, 8'h00);
      do_flush();
      run(2'b01, 2'b00, 8'h00, 8'h00);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0) do_flush();
         run(2'($urandom_range(1, 3)), 2'($urandom), 8'($urandom), 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic reset_seq_mid();
      ifc.wdata0 = 8'h77;
      for (int i = 0; i < 4; i++) tick();
      chk("mid_push_high", 32'(buf_push), 32'd1);
      clear_n = 1'b0;
      ifc.req = 2'b00;
      tick();
      chk("mid_push_drop", 32'(buf_push), 32'd0);
      chk("mid_no_ack", 32'(ifc.ack), 32'd0);
      chk("mid_count", 32'(count), 32'd0);
      reset_seq();
   endtask

endmodule
